oled_rect_cmd_sequencer: RTL and testbench

//  Streams a latched 11-byte SSD1331 draw-rectangle command frame (0x22 + 10 args) to the SPI byte transmitter.

---
 rtl/oled_rect_cmd_sequencer_if.sv | 13 +
 rtl/oled_rect_cmd_sequencer.sv | 104 ++++++++++
 tb/tb_oled_rect_cmd_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/oled_rect_cmd_sequencer_if.sv
// oled_rect_cmd_sequencer_if: start/frame request plus SPI byte valid/ready stream and status
interface oled_rect_cmd_sequencer_if;
  logic        start;
  logic [87:0] cmd_bytes;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  modport master (input start, cmd_bytes, tx_ready, output tx_data, tx_dc, tx_valid, busy, done);
  modport slave  (output start, cmd_bytes, tx_ready, input tx_data, tx_dc, tx_valid, busy, done);
endinterface

// File: rtl/oled_rect_cmd_sequencer.sv
// oled_rect_cmd_sequencer: streams an 11-byte SSD1331 draw-rectangle frame with settle wait and one-deep pending request.
// Optional CLEAR_BEFORE_DRAW_EN prepends a full-screen clear-window command and its own settle wait.
module oled_rect_cmd_sequencer #(
  parameter int WAIT_CYCLES = 1000,
  parameter int CLR_COL_END = 95,
  parameter int CLR_ROW_END = 63
) (
  input logic clk,
  input logic rst,
  oled_rect_cmd_sequencer_if.master bus
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
`ifdef CLEAR_BEFORE_DRAW_EN
  typedef enum logic [2:0] {IDLE, CLEAR, CLR_WAIT, DRAW, DRAW_WAIT, DONE} state_t;
  localparam state_t FIRST = CLEAR;
  localparam logic [39:0] CLR = {8'(CLR_ROW_END), 8'(CLR_COL_END), 16'h0000, 8'h25};
`else
  typedef enum logic [2:0] {IDLE, DRAW, DRAW_WAIT, DONE} state_t;
  localparam state_t FIRST = DRAW;
`endif
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [87:0]   frame_q, frame_d, pframe_q, pframe_d;
  logic          pend_q, pend_d;
  logic          hs;
  assign hs = bus.tx_valid && bus.tx_ready;
  assign bus.tx_dc = 1'b0;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
`ifdef CLEAR_BEFORE_DRAW_EN
  assign bus.tx_valid = state_q == DRAW || state_q == CLEAR;
  assign bus.tx_data = state_q == DRAW ? frame_q[{idx_q, 3'b000} +: 8] :
                       state_q == CLEAR ? CLR[{idx_q, 3'b000} +: 8] : 8'h00;
`else
  assign bus.tx_valid = state_q == DRAW;
  assign bus.tx_data = state_q == DRAW ? frame_q[{idx_q, 3'b000} +: 8] : 8'h00;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    pend_d = pend_q;
    pframe_d = pframe_q;
    // any start outside IDLE (DONE included) becomes the single pending frame, latest wins
    if (bus.start && state_q != IDLE) begin
      pend_d = 1'b1;
      pframe_d = bus.cmd_bytes;
    end
    case (state_q)
      IDLE: if (bus.start) begin
        frame_d = bus.cmd_bytes;
        state_d = FIRST;
      end
`ifdef CLEAR_BEFORE_DRAW_EN
      CLEAR: if (hs) begin
        idx_d = idx_q == 4'd4 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd4 ? CLR_WAIT : CLEAR;
        cnt_d = idx_q == 4'd4 ? CNT_LOAD : cnt_q;
      end
      CLR_WAIT: begin
        state_d = cnt_q == '0 ? DRAW : CLR_WAIT;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
`endif
      DRAW: if (hs) begin
        idx_d = idx_q == 4'd10 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd10 ? DRAW_WAIT : DRAW;
        cnt_d = idx_q == 4'd10 ? CNT_LOAD : cnt_q;
      end
      DRAW_WAIT: begin
        state_d = cnt_q == '0 ? DONE : DRAW_WAIT;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      DONE: if (bus.start || pend_q) begin
        frame_d = bus.start ? bus.cmd_bytes : pframe_q;
        pend_d = 1'b0;
        state_d = FIRST;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
      pend_q <= 1'b0;
      pframe_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      pend_q <= pend_d;
      pframe_q <= pframe_d;
    end
  end
endmodule

// File: tb/tb_oled_rect_cmd_sequencer.sv
// tb_oled_rect_cmd_sequencer: directed + random stimulus against a per-cycle script model of the expected output stream.
module tb_oled_rect_cmd_sequencer;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  oled_rect_cmd_sequencer_if bus();
  oled_rect_cmd_sequencer #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  // model: each frame is a script of slots; >=0 byte to send, -1 idle settle cycle, -2 done cycle
  int q[$];
  bit pend;
  logic [87:0] pend_f;
  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic load(input logic [87:0] c);
    q = {};
`ifdef CLEAR_BEFORE_DRAW_EN
    q.push_back(8'h25); q.push_back(0); q.push_back(0); q.push_back(95); q.push_back(63);
    for (int k = 0; k < W; k++) q.push_back(-1);
`endif
    for (int k = 0; k < 11; k++) q.push_back(int'(c[8*k +: 8]));
    for (int k = 0; k < W; k++) q.push_back(-1);
    q.push_back(-2);
  endtask
  function automatic logic [87:0] rnd_frame();
    logic [87:0] f;
    f[7:0] = 8'h22;
    for (int k = 1; k < 11; k++) f[8*k +: 8] = 8'($urandom);
    return f;
  endfunction
  task automatic step(input bit r, input bit s, input logic [87:0] c, input bit rdy);
    int h;
    h = q.size() != 0 ? q[0] : -3;
    chk("tx_valid", 32'(bus.tx_valid), 32'(h >= 0));
    if (h >= 0) chk("tx_data", 32'(bus.tx_data), 32'(h));
    chk("busy", 32'(bus.busy), 32'(q.size() != 0));
    chk("done", 32'(bus.done), 32'(h == -2));
    chk("tx_dc", 32'(bus.tx_dc), 32'd0);
    rst = r;
    bus.start = s;
    bus.cmd_bytes = c;
    bus.tx_ready = rdy;
    if (r) begin
      q = {};
      pend = 0;
    end else if (q.size() == 0) begin
      if (s) load(c);
    end else begin
      if (s) begin
        pend = 1;
        pend_f = c;
      end
      if (h >= 0) begin
        if (rdy) void'(q.pop_front());
      end else if (h == -1) begin
        void'(q.pop_front());
      end else begin
        void'(q.pop_front());
        if (pend) begin
          load(pend_f);
          pend = 0;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, '0, rdy);
  endtask
  logic [87:0] f1, fa, fb;
  initial begin
    bus.start = 0;
    bus.cmd_bytes = '0;
    bus.tx_ready = 0;
    pend = 0;
    pend_f = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    // T1: fixed frame, always ready
    f1 = {8'h3E, 8'h3F, 8'h00, 8'h3E, 8'h3F, 8'h00, 8'h2F, 8'h30, 8'h10, 8'h00, 8'h22};
    step(0, 1, f1, 1);
    idle(40, 1);
    // T2: alternating ready plus a 3-cycle stall
    step(0, 1, rnd_frame(), 0);
    for (int i = 0; i < 40; i++) step(0, 0, '0, (i % 2 == 0) && !(i >= 9 && i < 12));
    // T3: two starts mid-frame, latest wins
    fa = rnd_frame(); fa[31:24] = 8'h20;
    fb = rnd_frame(); fb[31:24] = 8'h40;
    step(0, 1, rnd_frame(), 1);
    idle(3, 1);
    step(0, 1, fa, 1);
    idle(3, 1);
    step(0, 1, fb, 1);
    idle(60, 1);
    // T4: reset mid-frame then a fresh frame
    step(0, 1, rnd_frame(), 1);
    idle(6, 1);
    step(1, 0, '0, 1);
    idle(2, 1);
    step(0, 1, rnd_frame(), 1);
    idle(40, 1);
    // T6: start held continuously
    for (int i = 0; i < 80; i++) step(0, 1, rnd_frame(), 1);
    idle(60, 1);
    // random traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 19) == 0, rnd_frame(), $urandom_range(0, 9) < 7);
    idle(60, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
